// File: rtl/serial_mag_cmp_ctrl_if.sv
// Operand/result handshake bundle for serial_mag_cmp_ctrl.
//   in_valid/in_ready/a_in/b_in             : operand pair, producer -> controller
//   out_valid/out_ready/equal/greater/lower : one-hot result, controller -> consumer
//   busy                                    : controller not idle
// master = producer/consumer side, slave = comparator controller.
interface serial_mag_cmp_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic             equal;
    logic             greater;
    logic             lower;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, equal, greater, lower, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, equal, greater, lower, busy
    );
endinterface

// File: rtl/serial_mag_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: one 1-bit slice scans the
// operands MSB first, one bit per clock, and returns one-hot
// equal/greater/lower over a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    serial_mag_cmp_ctrl_if.slave (operand in, result out, busy)
// Optional build macro: MAG_CMP_EARLY_EXIT_EN -- leave CMP on the first
// differing bit instead of always scanning all WIDTH bits.
module serial_mag_cmp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_mag_cmp_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic             decided;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             equal_q;
    logic             greater_q;
    logic             lower_q;

    // 1-bit comparator slice on the current MSBs
    logic slice_eq_c;
    logic slice_gt_c;
    logic slice_lt_c;
    assign slice_eq_c = a_sh[WIDTH-1] ~^ b_sh[WIDTH-1];
    assign slice_gt_c = a_sh[WIDTH-1] & ~b_sh[WIDTH-1];
    assign slice_lt_c = ~a_sh[WIDTH-1] & b_sh[WIDTH-1];

    // Sequencer: state, operand shifters, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            cnt         <= '0;
            decided     <= 1'b0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            lower_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= bus.a_in;
                        b_sh       <= bus.b_in;
                        cnt        <= CNT_W'(WIDTH - 1);
                        decided    <= 1'b0;
                        equal_q    <= 1'b0;
                        greater_q  <= 1'b0;
                        lower_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt - CNT_W'(1);
                    // first differing bit decides; later bits are masked
                    if (!decided && !slice_eq_c) begin
                        greater_q <= slice_gt_c;
                        lower_q   <= slice_lt_c;
                        decided   <= 1'b1;
                    end
`ifdef MAG_CMP_EARLY_EXIT_EN
                    if ((cnt == '0) || !slice_eq_c) begin
`else
                    if (cnt == '0) begin
`endif
                        // all bits matched -> equal
                        equal_q     <= !decided && slice_eq_c;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.equal     = equal_q;
    assign bus.greater   = greater_q;
    assign bus.lower     = lower_q;
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Directed + table-driven bench for serial_mag_cmp_ctrl at WIDTH=8.
module tb_serial_mag_cmp_ctrl;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    serial_mag_cmp_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_mag_cmp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         eq;
        logic         gt;
        logic         lt;
        int           stall;
        bit           poke;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // expected edges from accept to out_valid
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAG_CMP_EARLY_EXIT_EN
        for (int i = 0; i < int'(W); i++)
            if (a[W-1-i] != b[W-1-i]) return i + 1;
`endif
        if (a == b) return W;
        return W;
    endfunction

    // one full transaction; checks latency, one-hot, stall stability, handshake
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit poke,
                          output logic eq, output logic gt, output logic lt);
        int guard;
        int lat;
        @(negedge clk);
        guard = 0;
        while (!bus_if.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", int'(bus_if.in_ready), 1);
        bus_if.a_in      = a;
        bus_if.b_in      = b;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = (stall == 0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 50) begin
            chk("busy_in_cmp", int'(bus_if.busy), 1);
            if (poke) begin
                bus_if.in_valid = lat[0];
                bus_if.a_in     = ~a;
                bus_if.b_in     = a;
            end
            @(negedge clk);
            lat++;
        end
        bus_if.in_valid = 1'b0;
        chk("latency", lat, exp_lat(a, b));
        chk("ready_valid_exclusive", int'(bus_if.in_ready & bus_if.out_valid), 0);
        chk("onehot", int'(bus_if.equal) + int'(bus_if.greater) + int'(bus_if.lower), 1);
        eq = bus_if.equal;
        gt = bus_if.greater;
        lt = bus_if.lower;
        for (int s = 0; s < stall; s++) begin
            if (poke) bus_if.in_valid = s[0];
            @(negedge clk);
            chk("stall_hold", int'({bus_if.out_valid, bus_if.equal, bus_if.greater, bus_if.lower}),
                int'({1'b1, eq, gt, lt}));
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("post_handshake_ready", int'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 4);
        chk("flags_kept", int'({bus_if.equal, bus_if.greater, bus_if.lower}), int'({eq, gt, lt}));
    endtask

    vec_t vecs[10];

    initial begin
        logic eq, gt, lt;
        logic [W-1:0] ra, rb;
        int   seen_valid;

        n_pass  = 0;
        n_total = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.a_in      = '0;
        bus_if.b_in      = '0;
        bus_if.out_ready = 1'b1;

        vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[2] = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[3] = '{8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, 5, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 2, 1'b1};
        vecs[6] = '{8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vecs[7] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 0, 1'b1};
        vecs[9] = '{8'hC3, 8'h43, 1'b0, 1'b1, 1'b0, 3, 1'b0};

        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", int'(bus_if.in_ready), 1);
        chk("reset_busy", int'(bus_if.busy), 0);
        chk("reset_out_valid", int'(bus_if.out_valid), 0);
        chk("reset_flags", int'({bus_if.equal, bus_if.greater, bus_if.lower}), 0);

        // directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].poke, eq, gt, lt);
            chk($sformatf("vec%0d_flags", i), int'({eq, gt, lt}),
                int'({vecs[i].eq, vecs[i].gt, vecs[i].lt}));
        end

        // reset during the 4th CMP cycle discards the operation
        @(negedge clk);
        bus_if.a_in     = 8'hFF;
        bus_if.b_in     = 8'h00;
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midop_busy_before_reset", int'(bus_if.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midop_reset_state", int'({bus_if.in_ready, bus_if.busy, bus_if.out_valid}), 4);
        chk("midop_reset_flags", int'({bus_if.equal, bus_if.greater, bus_if.lower}), 0);
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_if.out_valid) seen_valid++;
        end
        chk("midop_no_result", seen_valid, 0);
        run_op(8'h00, 8'hFF, 0, 1'b0, eq, gt, lt);
        chk("after_reset_lower", int'({eq, gt, lt}), 1);

        // random back-to-back with stalls
        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = (k % 5 == 0) ? ra : W'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), eq, gt, lt);
            chk($sformatf("rand%0d_%02h_%02h", k, ra, rb), int'({eq, gt, lt}),
                int'({ra == rb, ra > rb, ra < rb}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
